// File: rtl/jtag_imem_chain_pkg.sv
// Shared types and sizes for the JTAG instruction-memory access chain.
package as_pack;

    localparam int imem_aw        = 10;
    localparam int imem_dw        = 32;
    localparam int imem_chain_len = 2 + imem_aw + imem_dw;

    typedef enum logic [1:0] {
        CMD_NOP       = 2'b00,
        CMD_WRITE     = 2'b01,
        CMD_READ      = 2'b10,
        CMD_WRITE_INC = 2'b11
    } imem_cmd_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } imem_state_t;

endpackage

// File: rtl/jtag_imem_chain_shift_reg.sv
// Generic L-bit JTAG data register: serial shift toward bit 0, or parallel capture.
module jtag_shift_reg #(
    parameter int L = 8
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         tdi_i,
    input  logic         shift_en_i,
    input  logic         capture_en_i,
    input  logic [L-1:0] cap_data_i,
    output logic [L-1:0] sr_o
);

    logic [L-1:0] sr_q;
    logic [L-1:0] sr_d;

    always_comb begin
        sr_d = sr_q;
        if (shift_en_i) begin
            sr_d = {tdi_i, sr_q[L-1:1]};
        end else if (capture_en_i) begin
            sr_d = cap_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sr_o = sr_q;

endmodule

// File: rtl/jtag_imem_chain.sv
// JTAG I-Mem access chain: shifted {cmd, addr, data} runs one req/ack access on update.
// Define IMEM_CHAIN_TIMEOUT_EN to abort requests left unacknowledged for TIMEOUT cycles.
module jtag_imem_chain
    import as_pack::*;
#(
    parameter int AW      = imem_aw,
    parameter int DW      = imem_dw,
    parameter int TIMEOUT = 64
) (
    input  logic          tck_i,
    input  logic          trst_ni,
    input  logic          tdi_i,
    output logic          tdo_o,
    input  logic          shift_i,
    input  logic          clock_i,
    input  logic          upd_i,
    input  logic          mode_i,
    output logic          mem_req_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i,
    input  logic          mem_ack_i
);

    localparam int L = 2 + AW + DW;

    logic [L-1:0]  sr_q;
    logic [L-1:0]  cap_word;
    imem_cmd_t     sr_cmd;
    logic [AW-1:0] sr_addr;

    imem_state_t   state_q;
    imem_cmd_t     cmd_q;
    logic [AW-1:0] addr_q;
    logic [AW-1:0] ptr_q;
    logic [DW-1:0] rdata_q;
    logic          err_q;
    logic          err_d;
    logic          req_q;
    logic          we_q;
    logic [AW-1:0] maddr_q;
    logic [DW-1:0] wdata_q;

    logic          busy;
    logic          capture_en;
    logic          shift_en;
    logic          upd_accept;
    logic          upd_overlap;
    logic          timeout_hit;

    assign busy        = (state_q == ST_REQ);
    assign shift_en    = clock_i & shift_i;
    assign capture_en  = clock_i & ~shift_i;
    assign upd_accept  = upd_i & mode_i & ~busy;
    assign upd_overlap = upd_i & mode_i & busy;

    assign sr_cmd   = imem_cmd_t'(sr_q[L-1:L-2]);
    assign sr_addr  = sr_q[AW+DW-1:DW];
    assign cap_word = {err_q, busy, ptr_q, rdata_q};

    jtag_shift_reg #(
        .L (L)
    ) u_sr (
        .clk_i        (tck_i),
        .rst_ni       (trst_ni),
        .tdi_i        (tdi_i),
        .shift_en_i   (shift_en),
        .capture_en_i (capture_en),
        .cap_data_i   (cap_word),
        .sr_o         (sr_q)
    );

    // A capture clears the sticky error, but an error raised on the same edge survives it.
    assign err_d = (err_q & ~capture_en) | upd_overlap | timeout_hit;

`ifdef IMEM_CHAIN_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] tmo_cnt_q;

    assign timeout_hit = busy & ~mem_ack_i & (tmo_cnt_q == CW'(TIMEOUT - 1));

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            tmo_cnt_q <= '0;
        end else if (!busy) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_q + CW'(1);
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge tck_i or negedge trst_ni) begin
        if (!trst_ni) begin
            state_q <= ST_IDLE;
            cmd_q   <= CMD_NOP;
            addr_q  <= '0;
            ptr_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
        end else begin
            err_q <= err_d;
            case (state_q)
                ST_IDLE: begin
                    if (upd_accept) begin
                        cmd_q   <= sr_cmd;
                        addr_q  <= sr_addr;
                        wdata_q <= sr_q[DW-1:0];
                        if (sr_cmd != CMD_NOP) begin
                            state_q <= ST_REQ;
                            req_q   <= 1'b1;
                            we_q    <= (sr_cmd == CMD_WRITE) || (sr_cmd == CMD_WRITE_INC);
                            maddr_q <= (sr_cmd == CMD_WRITE_INC) ? ptr_q : sr_addr;
                        end
                    end
                end
                ST_REQ: begin
                    if (mem_ack_i) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                        if (cmd_q == CMD_READ) begin
                            rdata_q <= mem_rdata_i;
                        end
                        ptr_q <= (cmd_q == CMD_WRITE_INC) ? ptr_q + AW'(1) : addr_q + AW'(1);
                    end else if (timeout_hit) begin
                        state_q <= ST_IDLE;
                        req_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign tdo_o       = sr_q[0];
    assign mem_req_o   = req_q;
    assign mem_we_o    = we_q;
    assign mem_addr_o  = maddr_q;
    assign mem_wdata_o = wdata_q;

endmodule

// File: tb/tb_jtag_imem_chain.sv
// Directed bench for jtag_imem_chain: scans commands in, plays the I-Mem side, scans status out.
module tb_jtag_imem_chain;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int L  = 2 + AW + DW;

    logic          tck;
    logic          trst_n;
    logic          tdi;
    logic          tdo;
    logic          shift;
    logic          clock;
    logic          upd;
    logic          mode;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;

    int tests_run    = 0;
    int tests_failed = 0;

    jtag_imem_chain #(
        .AW      (AW),
        .DW      (DW),
        .TIMEOUT (64)
    ) dut (
        .tck_i       (tck),
        .trst_ni     (trst_n),
        .tdi_i       (tdi),
        .tdo_o       (tdo),
        .shift_i     (shift),
        .clock_i     (clock),
        .upd_i       (upd),
        .mode_i      (mode),
        .mem_req_o   (mem_req),
        .mem_we_o    (mem_we),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ack_i   (mem_ack)
    );

    initial tck = 1'b0;
    always #5 tck = ~tck;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge tck);
        #1;
    endtask

    task automatic shift_word(input logic [1:0] c, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic [L-1:0] w;
        w     = {c, a, d};
        clock = 1'b1;
        shift = 1'b1;
        for (int i = 0; i < L; i++) begin
            tdi = w[i];
            tick();
        end
        clock = 1'b0;
        shift = 1'b0;
        tdi   = 1'b0;
    endtask

    task automatic scan_out(output logic [L-1:0] w);
        shift = 1'b1;
        tdi   = 1'b0;
        for (int i = 0; i < L; i++) begin
            w[i] = tdo;
            tick();
        end
        clock = 1'b0;
        shift = 1'b0;
    endtask

    task automatic capture_scan(output logic [L-1:0] w);
        clock = 1'b1;
        shift = 1'b0;
        tick();
        scan_out(w);
    endtask

    task automatic pulse_upd();
        upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    // Waits (bounded) for a request, holds ack off for delay-1 cycles, then acks.
    task automatic serve(input int delay, input logic [DW-1:0] rd,
                         output logic we, output logic [AW-1:0] a, output logic [DW-1:0] wd,
                         output logic stable, output logic seen);
        int n;
        n      = 0;
        seen   = 1'b0;
        stable = 1'b0;
        we     = 1'bx;
        a      = 'x;
        wd     = 'x;
        while (mem_req !== 1'b1 && n < 8) begin
            tick();
            n++;
        end
        if (mem_req === 1'b1) begin
            seen   = 1'b1;
            stable = 1'b1;
            we     = mem_we;
            a      = mem_addr;
            wd     = mem_wdata;
            for (int i = 1; i < delay; i++) begin
                tick();
                if (mem_req !== 1'b1 || mem_we !== we || mem_addr !== a || mem_wdata !== wd)
                    stable = 1'b0;
            end
            mem_ack   = 1'b1;
            mem_rdata = rd;
            tick();
            mem_ack   = 1'b0;
            mem_rdata = '0;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [L-1:0] w;
        tests_run++;
        if ({tdo, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %h required 0", {tdo, mem_req, mem_we, mem_addr, mem_wdata});
        end
        trst_n = 1'b1;
        tick();
        clock = 1'b1;
        shift = 1'b1;
        tdi   = 1'b1;
        for (int i = 0; i < L + 4; i++) tick();
        tests_run++;
        if (tdo !== 1'b1) begin
            tests_failed++;
            $display("FAIL shift_ones_tdo: got %b required 1", tdo);
        end
        #2 trst_n = 1'b0;
        #1;
        tests_run++;
        if ({tdo, mem_req, mem_we, mem_addr, mem_wdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid_shift: got %h required 0", {tdo, mem_req, mem_we, mem_addr, mem_wdata});
        end
        clock = 1'b0;
        shift = 1'b0;
        tdi   = 1'b0;
        #2 trst_n = 1'b1;
        tick();
        capture_scan(w);
        tests_run++;
        if (w !== '0) begin
            tests_failed++;
            $display("FAIL reset_capture: got %h required 0", w);
        end
    endtask

    task automatic test_reset_in_req();
        logic [L-1:0] w;
        shift_word(2'b01, 10'h155, 32'h11111111);
        pulse_upd();
        tests_run++;
        if (mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_req_issue: req got %b required 1", mem_req);
        end
        #2 trst_n = 1'b0;
        #1;
        tests_run++;
        if ({mem_req, mem_addr} !== '0) begin
            tests_failed++;
            $display("FAIL rst_req_drop: req/addr got %h required 0", {mem_req, mem_addr});
        end
        #2 trst_n = 1'b1;
        tick();
        capture_scan(w);
        tests_run++;
        if (w !== '0) begin
            tests_failed++;
            $display("FAIL rst_req_capture: got %h required 0", w);
        end
    endtask

    task automatic test_write();
        logic [L-1:0] w;
        logic we, stable, seen;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        int n_high;
        shift_word(2'b01, 10'h005, 32'hDEADBEEF);
        pulse_upd();
        tests_run++;
        if (mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL write_latency: req got %b required 1 one cycle after update", mem_req);
        end
        serve(3, 32'h0, we, a, wd, stable, seen);
        tests_run++;
        if ({seen, stable, we, a, wd} !== {1'b1, 1'b1, 1'b1, 10'h005, 32'hDEADBEEF}) begin
            tests_failed++;
            $display("FAIL write_request: got seen=%b stable=%b we=%b addr=%h wdata=%h required 1 1 1 005 deadbeef",
                     seen, stable, we, a, wd);
        end
        n_high = 0;
        for (int i = 0; i < 4; i++) begin
            if (mem_req === 1'b1) n_high++;
            tick();
        end
        tests_run++;
        if (n_high !== 0) begin
            tests_failed++;
            $display("FAIL write_single_req: req high %0d cycles after ack, required 0", n_high);
        end
        capture_scan(w);
        tests_run++;
        if (w !== {1'b0, 1'b0, 10'h006, 32'h0}) begin
            tests_failed++;
            $display("FAIL write_capture: got %h required %h", w, {1'b0, 1'b0, 10'h006, 32'h0});
        end
    endtask

    task automatic test_read();
        logic [L-1:0] w;
        logic we, stable, seen;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        shift_word(2'b10, 10'h3FF, 32'h0);
        pulse_upd();
        serve(1, 32'h12345678, we, a, wd, stable, seen);
        tests_run++;
        if ({seen, we, a, mem_req} !== {1'b1, 1'b0, 10'h3FF, 1'b0}) begin
            tests_failed++;
            $display("FAIL read_request: got seen=%b we=%b addr=%h req_after=%b required 1 0 3ff 0",
                     seen, we, a, mem_req);
        end
        capture_scan(w);
        tests_run++;
        if (w !== {1'b0, 1'b0, 10'h000, 32'h12345678}) begin
            tests_failed++;
            $display("FAIL read_capture: got %h required %h", w, {1'b0, 1'b0, 10'h000, 32'h12345678});
        end
    endtask

    task automatic test_write_inc();
        logic [L-1:0] w;
        logic we, stable, seen;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        shift_word(2'b01, 10'h010, 32'hA0A0A0A0);
        pulse_upd();
        serve(2, 32'h0, we, a, wd, stable, seen);
        tests_run++;
        if ({seen, we, a, wd} !== {1'b1, 1'b1, 10'h010, 32'hA0A0A0A0}) begin
            tests_failed++;
            $display("FAIL winc_base: got seen=%b we=%b addr=%h wdata=%h required 1 1 010 a0a0a0a0", seen, we, a, wd);
        end
        for (int k = 1; k <= 3; k++) begin
            shift_word(2'b11, 10'h2AA, 32'hB000_0000 + k);
            pulse_upd();
            serve(1, 32'h0, we, a, wd, stable, seen);
            tests_run++;
            if ({seen, we, a, wd} !== {1'b1, 1'b1, 10'h010 + 10'(k), 32'hB000_0000 + k}) begin
                tests_failed++;
                $display("FAIL winc_%0d: got seen=%b we=%b addr=%h wdata=%h required 1 1 %h %h",
                         k, seen, we, a, wd, 10'h010 + 10'(k), 32'hB000_0000 + k);
            end
        end
        capture_scan(w);
        tests_run++;
        if (w !== {1'b0, 1'b0, 10'h014, 32'h12345678}) begin
            tests_failed++;
            $display("FAIL winc_capture: got %h required %h", w, {1'b0, 1'b0, 10'h014, 32'h12345678});
        end
    endtask

    task automatic test_overlap();
        logic [L-1:0] w;
        logic we, stable, seen;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        shift_word(2'b01, 10'h020, 32'h0BADF00D);
        pulse_upd();
        shift_word(2'b10, 10'h3AB, 32'h0);
        // Capture and overlapping update on the same edge.
        clock = 1'b1;
        shift = 1'b0;
        upd   = 1'b1;
        tick();
        upd = 1'b0;
        scan_out(w);
        tests_run++;
        if (w !== {1'b0, 1'b1, 10'h014, 32'h12345678}) begin
            tests_failed++;
            $display("FAIL overlap_same_edge: got %h required %h", w, {1'b0, 1'b1, 10'h014, 32'h12345678});
        end
        capture_scan(w);
        tests_run++;
        if (w !== {1'b1, 1'b1, 10'h014, 32'h12345678}) begin
            tests_failed++;
            $display("FAIL overlap_err_set: got %h required %h", w, {1'b1, 1'b1, 10'h014, 32'h12345678});
        end
        capture_scan(w);
        tests_run++;
        if (w !== {1'b0, 1'b1, 10'h014, 32'h12345678}) begin
            tests_failed++;
            $display("FAIL overlap_err_clear: got %h required %h", w, {1'b0, 1'b1, 10'h014, 32'h12345678});
        end
        serve(1, 32'h0, we, a, wd, stable, seen);
        tests_run++;
        if ({seen, we, a, wd} !== {1'b1, 1'b1, 10'h020, 32'h0BADF00D}) begin
            tests_failed++;
            $display("FAIL overlap_first_kept: got seen=%b we=%b addr=%h wdata=%h required 1 1 020 0badf00d",
                     seen, we, a, wd);
        end
        capture_scan(w);
        tests_run++;
        if (w !== {1'b0, 1'b0, 10'h021, 32'h12345678}) begin
            tests_failed++;
            $display("FAIL overlap_done: got %h required %h", w, {1'b0, 1'b0, 10'h021, 32'h12345678});
        end
    endtask

    task automatic test_mode_off();
        logic [L-1:0] w;
        int n_high;
        mode = 1'b0;
        shift_word(2'b01, 10'h100, 32'h55555555);
        pulse_upd();
        n_high = 0;
        for (int i = 0; i < 5; i++) begin
            if (mem_req === 1'b1) n_high++;
            tick();
        end
        mode = 1'b1;
        tests_run++;
        if (n_high !== 0) begin
            tests_failed++;
            $display("FAIL mode_off_no_req: req high %0d cycles, required 0", n_high);
        end
        capture_scan(w);
        tests_run++;
        if (w !== {1'b0, 1'b0, 10'h021, 32'h12345678}) begin
            tests_failed++;
            $display("FAIL mode_off_capture: got %h required %h", w, {1'b0, 1'b0, 10'h021, 32'h12345678});
        end
    endtask

    task automatic test_ack_idle();
        logic [L-1:0] w;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFF0000;
        tick();
        tick();
        mem_ack   = 1'b0;
        mem_rdata = '0;
        capture_scan(w);
        tests_run++;
        if (w !== {1'b0, 1'b0, 10'h021, 32'h12345678}) begin
            tests_failed++;
            $display("FAIL ack_idle_ignored: got %h required %h", w, {1'b0, 1'b0, 10'h021, 32'h12345678});
        end
    endtask

    task automatic test_mode_fall();
        logic [L-1:0] w;
        logic we, stable, seen;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        shift_word(2'b10, 10'h040, 32'h0);
        pulse_upd();
        mode = 1'b0;
        serve(3, 32'hCAFEF00D, we, a, wd, stable, seen);
        mode = 1'b1;
        tests_run++;
        if ({seen, stable, we, a} !== {1'b1, 1'b1, 1'b0, 10'h040}) begin
            tests_failed++;
            $display("FAIL mode_fall_req: got seen=%b stable=%b we=%b addr=%h required 1 1 0 040", seen, stable, we, a);
        end
        capture_scan(w);
        tests_run++;
        if (w !== {1'b0, 1'b0, 10'h041, 32'hCAFEF00D}) begin
            tests_failed++;
            $display("FAIL mode_fall_capture: got %h required %h", w, {1'b0, 1'b0, 10'h041, 32'hCAFEF00D});
        end
    endtask

    task automatic test_timeout();
        logic [L-1:0] w;
        int n;
        shift_word(2'b01, 10'h080, 32'h77777777);
        pulse_upd();
`ifdef IMEM_CHAIN_TIMEOUT_EN
        n = 0;
        while (mem_req === 1'b1 && n < 200) begin
            tick();
            n++;
        end
        tests_run++;
        if (n !== 64) begin
            tests_failed++;
            $display("FAIL timeout_cycles: req high %0d cycles, required 64", n);
        end
        capture_scan(w);
        tests_run++;
        if (w !== {1'b1, 1'b0, 10'h041, 32'hCAFEF00D}) begin
            tests_failed++;
            $display("FAIL timeout_capture: got %h required %h", w, {1'b1, 1'b0, 10'h041, 32'hCAFEF00D});
        end
`else
        n = 0;
        for (int i = 0; i < 100; i++) begin
            if (mem_req === 1'b1) n++;
            tick();
        end
        tests_run++;
        if (n !== 100 || mem_req !== 1'b1) begin
            tests_failed++;
            $display("FAIL no_timeout_wait: req high %0d of 100 cycles (now %b), required 100 (1)", n, mem_req);
        end
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        capture_scan(w);
        tests_run++;
        if (w !== {1'b0, 1'b0, 10'h081, 32'hCAFEF00D}) begin
            tests_failed++;
            $display("FAIL no_timeout_capture: got %h required %h", w, {1'b0, 1'b0, 10'h081, 32'hCAFEF00D});
        end
`endif
    endtask

    // ---------------- sequence ----------------
    initial begin
        trst_n    = 1'b0;
        tdi       = 1'b0;
        shift     = 1'b0;
        clock     = 1'b0;
        upd       = 1'b0;
        mode      = 1'b1;
        mem_rdata = '0;
        mem_ack   = 1'b0;
        repeat (3) @(posedge tck);
        #1;
        test_reset();
        test_reset_in_req();
        test_write();
        test_read();
        test_write_inc();
        test_overlap();
        test_mode_off();
        test_ack_idle();
        test_mode_fall();
        test_timeout();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
